r88_intctl: RTL and testbench
=============================

# r88_intctl

Parametrised interrupt controller for the Rocket88 core, successor to the single `irq` and `nmiReq` pins on the core boundary. It accepts NUM_IRQ maskable sources, each configurable as level- or edge-triggered, plus one edge-triggered NMI. It prioritises and nests them, then presents one request and a 16-bit vector address to `r88_decoder` through a request/acknowledge handshake. It tracks in-service state so that only strictly higher-priority interrupts can nest.

## Interface
- NUM_IRQ, 8: number of maskable sources, legal range 1..16; index 0 has the highest priority.
- IRQ_VEC_BASE, 16'hFFE0: vector address of IRQ 0.
- NMI_VEC, 16'hFFFA: NMI vector address.
- sysClock  in  1  system clock; all logic on its rising edge.
- resetReq  in  1  reset, synchronous, active-high.
- irqIn  in  NUM_IRQ  maskable interrupt sources.
- nmiReq  in  1  NMI source; its rising edge is the event.
- irqEn  in  1  global IRQ enable, taken from the core flag.
- cfgWrite  in  1  configuration write strobe.
- cfgSel  in  2  configuration target: 0 = mask, 1 = mode, 2 = clear-pending, 3 = set-pending.
- cfgData  in  NUM_IRQ  configuration write data.
- intAck  in  1  decoder has taken the presented interrupt.
- intDone  in  1  return-from-interrupt pulse.
- intReq  out  1  interrupt request to the decoder.
- intNmi  out  1  the presented request is the NMI.
- intVector  out  16  vector address of the presented request.
- pending  out  NUM_IRQ  pending bits.
- inService  out  NUM_IRQ  in-service bits.

## Operation
- **Reset values.**
  - Registers: mask=0 (all sources disabled), mode=0 (all level), pending=0, inService=0, nmiService=0, nmiPend=0, NMI edge flop=1.
  - Outputs: intReq=0, intNmi=0, intVector=16'h0000.
  - State: IDLE.
  - Reset mid-handshake drops the request with no side effects.
- **Pending bit update.**
  - Level mode: pending[i] is irqIn[i], registered.
  - Edge mode: a rising edge on irqIn[i] sets pending[i]. It is cleared by intAck for that source, or by a cfgSel=2 write with a 1 in that bit.
  - cfgSel=3 sets edge-mode pending bits; in level mode it has no effect.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **NMI pending.**
  - A rising edge on nmiReq sets nmiPend.
  - intAck of the NMI clears it.
  - An edge arriving while the NMI is already pending is merged into the existing request.
- **Candidate selection.**
  - The NMI is a candidate when nmiPend=1 and nmiService=0.
  - IRQ i is a candidate when pending[i], mask[i] and irqEn are all 1, and no inService bit at index ≤ i is set.
  - The NMI beats every IRQ. Among IRQs, the lowest index wins.
- **State machine.**
  - IDLE: if a candidate exists, latch its id, intNmi and intVector, then go to REQ.
  - REQ, intAck=1: set inService[id] (or nmiService), clear edge-mode pending / nmiPend, go to IDLE.
  - REQ, intAck=0, latched candidate no longer valid or an NMI now present while serving an IRQ: abandon and go to IDLE. This happens when a level source is withdrawn, its mask bit or irqEn drops, or an NMI arrives.
  - REQ, otherwise: hold.
- **intDone.**
  - Clears nmiService if it is set. Otherwise it clears the lowest-index set inService bit, which is the most recently nested one.
  - intDone with nothing in service is ignored.
  - intDone and intAck in the same cycle: the clear applies to the old in-service state and the ack's set is applied afterwards.
- **Vector arithmetic.**
  - IRQ vector = IRQ_VEC_BASE + 2*id, 16-bit, wrapping modulo 2^16.
  - NMI vector = NMI_VEC.
- **Configuration writes** use only bits [NUM_IRQ-1:0] of cfgData and take effect on the next cycle.

## Timing
- Source sampled at edge N → pending bit valid after N → state=REQ and intReq=1 after edge N+1. Latency is 2 cycles, for level, edge and NMI sources alike.
- intReq, intNmi and intVector come directly from registers. They are stable for the whole time intReq=1.
- The ack is sampled at an edge with intReq=1. intReq falls after that edge.
- Minimum gap between consecutive requests: 1 IDLE cycle.
- intAck while intReq=0 is ignored.

## Structure
- Shared package `r88_pkg` holds:
  - the state encoding (IDLE, REQ);
  - the cfgSel codes (CFG_MASK, CFG_MODE, CFG_CLR, CFG_SET);
  - the vector width constant (16).
- Sub-module `r88_prio_enc #(N)`: a combinational lowest-index-wins encoder with outputs valid and index [3:0]. It is instanced twice: once for candidate selection, once for the intDone clear.

## Test plan
- **Level IRQ 3, mask=8'h08, irqEn=1:** irqIn[3]=1 → intReq high 2 cycles later, intVector=16'hFFE6, intNmi=0. Ack → inService=8'h08. intDone → inService=0.
- **Edge IRQ 5:** a 1-cycle pulse still yields a request with intVector=16'hFFEA. Edges during service do not re-request until intDone. cfgSel=2 with data 8'h20 clears pending, and an edge in that same cycle still leaves pending[5]=1.
- **Nesting:** with IRQ 4 in service, assert IRQs 6 and 2 together → only IRQ 2 is requested (vector 16'hFFE4). intDone clears bit 2 first; IRQ 6 stays blocked until bit 4 is cleared.
- **NMI:** with IRQ 1 in REQ and unacked, a rising edge on nmiReq → the IRQ request is abandoned, then intNmi=1 and intVector=16'hFFFA. A second NMI edge before intDone is merged. irqEn=0 does not block the NMI.
- **Withdrawal and reset:** a level IRQ dropped during REQ → intReq falls with no inService change. resetReq in REQ → all outputs return to reset values the next cycle.
- **Parameters:** NUM_IRQ=16 with IRQ_VEC_BASE=16'hFFF0, IRQ 15 → intVector=16'h000E (wraps modulo 2^16).

Source files
------------

// File: rtl/r88_pkg.sv
// Shared definitions for the Rocket88 interrupt controller: FSM state
// encoding, configuration-target codes and the vector width.
package r88_pkg;

  localparam int VEC_W = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CFG_MASK = 2'd0,
    CFG_MODE = 2'd1,
    CFG_CLR  = 2'd2,
    CFG_SET  = 2'd3
  } cfg_sel_t;

endpackage

// File: rtl/r88_intctl_if.sv
// Bundle of the source, configuration and decoder-handshake signals of
// r88_intctl. The master side is the controller, the slave side the core.
interface r88_intctl_if
  import r88_pkg::*;
#(
  parameter int NUM_IRQ = 8
) ();

  logic [NUM_IRQ-1:0] irqIn;
  logic               nmiReq;
  logic               irqEn;
  logic               cfgWrite;
  logic [1:0]         cfgSel;
  logic [NUM_IRQ-1:0] cfgData;
  logic               intAck;
  logic               intDone;
  logic               intReq;
  logic               intNmi;
  logic [VEC_W-1:0]   intVector;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] inService;

  modport master (
    input  irqIn, nmiReq, irqEn, cfgWrite, cfgSel, cfgData, intAck, intDone,
    output intReq, intNmi, intVector, pending, inService
  );

  modport slave (
    output irqIn, nmiReq, irqEn, cfgWrite, cfgSel, cfgData, intAck, intDone,
    input  intReq, intNmi, intVector, pending, inService
  );

endinterface

// File: rtl/r88_prio_enc.sv
// Lowest-index-wins priority encoder; index is meaningless when valid=0.
module r88_prio_enc
  import r88_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    // NOTE: default assignments first keep this block free of inferred latches.
    valid = |req;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/r88_intctl.sv
// Rocket88 interrupt controller: per-source level/edge pending logic, an
// edge-triggered NMI, nesting by in-service state and a request/ack FSM.
module r88_intctl
  import r88_pkg::*;
#(
  parameter int               NUM_IRQ      = 8,
  parameter logic [VEC_W-1:0] IRQ_VEC_BASE = 16'hFFE0,
  parameter logic [VEC_W-1:0] NMI_VEC      = 16'hFFFA
) (
  input  logic          sysClock,
  input  logic          resetReq,
  r88_intctl_if.master  bus
);

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  state_t           state_q, state_d;
  irq_vec_t         mask_q, mask_d;
  irq_vec_t         mode_q, mode_d;
  irq_vec_t         pending_q, pending_d;
  irq_vec_t         in_service_q, in_service_d;
  irq_vec_t         irq_prev_q, irq_prev_d;
  logic             nmi_prev_q, nmi_prev_d;
  logic             nmi_pend_q, nmi_pend_d;
  logic             nmi_service_q, nmi_service_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic             int_req_q, int_req_d;
  logic             int_nmi_q, int_nmi_d;
  logic [VEC_W-1:0] int_vector_q, int_vector_d;

  cfg_sel_t         cfg_sel;
  irq_vec_t         cfg_set, cfg_clr, edge_set, edge_clr;
  irq_vec_t         irq_rise, blocked, irq_cand, id_oh, isr_oh;
  logic             nmi_rise, nmi_cand;
  logic             sel_valid, isr_valid;
  logic [IDX_W-1:0] sel_idx, isr_idx;
  logic             ack_irq, ack_nmi, done_irq, done_nmi, abandon;

  assign cfg_sel  = cfg_sel_t'(bus.cfgSel);
  assign cfg_set  = (bus.cfgWrite && cfg_sel == CFG_SET) ? bus.cfgData : '0;
  assign cfg_clr  = (bus.cfgWrite && cfg_sel == CFG_CLR) ? bus.cfgData : '0;
  assign irq_rise = bus.irqIn & ~irq_prev_q;
  assign nmi_rise = bus.nmiReq & ~nmi_prev_q;

  // A source is blocked when anything at its own or higher priority is in service.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    blocked = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      seen       = seen | in_service_q[i];
      blocked[i] = seen;
    end
  end

  assign irq_cand = pending_q & mask_q & {NUM_IRQ{bus.irqEn}} & ~blocked;
  assign nmi_cand = nmi_pend_q & ~nmi_service_q;

  r88_prio_enc #(.N(NUM_IRQ)) u_sel_enc (
    .req   (irq_cand),
    .valid (sel_valid),
    .index (sel_idx)
  );

  r88_prio_enc #(.N(NUM_IRQ)) u_done_enc (
    .req   (in_service_q),
    .valid (isr_valid),
    .index (isr_idx)
  );

  assign id_oh    = irq_vec_t'(1) << id_q;
  assign isr_oh   = irq_vec_t'(1) << isr_idx;
  assign ack_irq  = (state_q == ST_REQ) && bus.intAck && !int_nmi_q;
  assign ack_nmi  = (state_q == ST_REQ) && bus.intAck && int_nmi_q;
  assign done_nmi = bus.intDone && nmi_service_q;
  assign done_irq = bus.intDone && !nmi_service_q && isr_valid;
  assign abandon  = !int_nmi_q && (!(|(irq_cand & id_oh)) || nmi_cand);

  // Pending, in-service and configuration registers.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (bus.cfgWrite && cfg_sel == CFG_MASK) mask_d = bus.cfgData;
    if (bus.cfgWrite && cfg_sel == CFG_MODE) mode_d = bus.cfgData;

    edge_set  = (irq_rise | cfg_set) & mode_q;
    edge_clr  = cfg_clr | (ack_irq ? id_oh : '0);
    pending_d = (mode_q & ((pending_q & ~edge_clr) | edge_set))
              | (~mode_q & bus.irqIn);

    nmi_pend_d = (nmi_pend_q & ~ack_nmi) | nmi_rise;

    // Completion clears the old in-service state before a same-cycle ack sets.
    in_service_d  = (in_service_q & ~(done_irq ? isr_oh : '0))
                  | (ack_irq ? id_oh : '0);
    nmi_service_d = (nmi_service_q & ~done_nmi) | ack_nmi;

    irq_prev_d = bus.irqIn;
    nmi_prev_d = bus.nmiReq;
  end

  // Request FSM; every output is the next value of its own register.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    int_req_d    = int_req_q;
    int_nmi_d    = int_nmi_q;
    int_vector_d = int_vector_q;
    case (state_q)
      ST_IDLE: begin
        if (nmi_cand) begin
          state_d      = ST_REQ;
          int_req_d    = 1'b1;
          int_nmi_d    = 1'b1;
          int_vector_d = NMI_VEC;
        end else if (sel_valid) begin
          state_d      = ST_REQ;
          id_d         = sel_idx;
          int_req_d    = 1'b1;
          int_nmi_d    = 1'b0;
          int_vector_d = IRQ_VEC_BASE + VEC_W'({sel_idx, 1'b0});
        end
      end
      ST_REQ: begin
        if (bus.intAck || abandon) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
          int_nmi_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (resetReq) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      mode_q        <= '0;
      pending_q     <= '0;
      in_service_q  <= '0;
      irq_prev_q    <= '0;
      nmi_prev_q    <= 1'b1;
      nmi_pend_q    <= 1'b0;
      nmi_service_q <= 1'b0;
      id_q          <= '0;
      int_req_q     <= 1'b0;
      int_nmi_q     <= 1'b0;
      int_vector_q  <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      mode_q        <= mode_d;
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      irq_prev_q    <= irq_prev_d;
      nmi_prev_q    <= nmi_prev_d;
      nmi_pend_q    <= nmi_pend_d;
      nmi_service_q <= nmi_service_d;
      id_q          <= id_d;
      int_req_q     <= int_req_d;
      int_nmi_q     <= int_nmi_d;
      int_vector_q  <= int_vector_d;
    end
  end

  assign bus.intReq    = int_req_q;
  assign bus.intNmi    = int_nmi_q;
  assign bus.intVector = int_vector_q;
  assign bus.pending   = pending_q;
  assign bus.inService = in_service_q;

endmodule

// File: tb/tb_r88_intctl.sv
// Directed bench for r88_intctl: expected requests are queued as stimulus is
// applied and compared when intReq rises; a 16-source instance covers wrap.
module tb_r88_intctl;
  import r88_pkg::*;

  typedef struct packed {
    logic        nmi;
    logic [15:0] vec;
  } exp_t;

  logic sysClock;
  logic resetReq;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  r88_intctl_if #(.NUM_IRQ(8))  b ();
  r88_intctl_if #(.NUM_IRQ(16)) b16 ();

  r88_intctl #(.NUM_IRQ(8)) dut (
    .sysClock (sysClock),
    .resetReq (resetReq),
    .bus      (b)
  );

  r88_intctl #(.NUM_IRQ(16), .IRQ_VEC_BASE(16'hFFF0), .NMI_VEC(16'hFFFA)) dut16 (
    .sysClock (sysClock),
    .resetReq (resetReq),
    .bus      (b16)
  );

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysClock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic nmi, input logic [15:0] vec);
    exp_t e;
    e.nmi = nmi;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  // Waits a bounded number of cycles for a request, then scores it.
  task automatic wait_req(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (b.intReq !== 1'b1 && n < 8) begin
      tick(1);
      n++;
    end
    check({tag, "_req"}, 32'(b.intReq), 32'h1);
    check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'h1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_nmi"}, 32'(b.intNmi), 32'(e.nmi));
      check({tag, "_vec"}, 32'(b.intVector), 32'(e.vec));
    end
  endtask

  task automatic cfg(input cfg_sel_t sel, input logic [7:0] data);
    b.cfgWrite = 1'b1;
    b.cfgSel   = sel;
    b.cfgData  = data;
    tick(1);
    b.cfgWrite = 1'b0;
    b.cfgData  = '0;
  endtask

  task automatic ack();
    b.intAck = 1'b1;
    tick(1);
    b.intAck = 1'b0;
  endtask

  task automatic done();
    b.intDone = 1'b1;
    tick(1);
    b.intDone = 1'b0;
  endtask

  initial begin
    int n;
    tests_run    = 0;
    tests_failed = 0;
    b.irqIn = '0;   b.nmiReq = 1'b1; b.irqEn = 1'b0; b.cfgWrite = 1'b0;
    b.cfgSel = '0;  b.cfgData = '0;  b.intAck = 1'b0; b.intDone = 1'b0;
    b16.irqIn = '0; b16.nmiReq = 1'b0; b16.irqEn = 1'b0; b16.cfgWrite = 1'b0;
    b16.cfgSel = '0; b16.cfgData = '0; b16.intAck = 1'b0; b16.intDone = 1'b0;

    // Reset values; nmiReq held high through reset must not count as an edge.
    resetReq = 1'b1;
    tick(2);
    check("rst_req", 32'(b.intReq), 32'h0);
    check("rst_nmi", 32'(b.intNmi), 32'h0);
    check("rst_vec", 32'(b.intVector), 32'h0);
    check("rst_pend", 32'(b.pending), 32'h0);
    check("rst_isr", 32'(b.inService), 32'h0);
    resetReq = 1'b0;
    tick(3);
    check("rst_no_nmi_edge", 32'(b.intReq), 32'h0);
    b.nmiReq = 1'b0;
    tick(1);

    // Level IRQ 3 with two-cycle latency.
    cfg(CFG_MASK, 8'h08);
    b.irqEn = 1'b1;
    b.irqIn = 8'h08;
    push_exp(1'b0, 16'hFFE6);
    tick(1);
    check("lvl_pend", 32'(b.pending), 32'h08);
    check("lvl_lat1", 32'(b.intReq), 32'h0);
    tick(1);
    wait_req("lvl3");
    ack();
    check("lvl_ack_drop", 32'(b.intReq), 32'h0);
    check("lvl_isr", 32'(b.inService), 32'h08);
    tick(2);
    check("lvl_blocked", 32'(b.intReq), 32'h0);
    b.irqIn = '0;
    done();
    check("lvl_done", 32'(b.inService), 32'h0);

    // Edge IRQ 5: single-cycle pulse, re-arm during service, clear/set writes.
    cfg(CFG_MODE, 8'h20);
    cfg(CFG_MASK, 8'h20);
    b.irqIn = 8'h20;
    push_exp(1'b0, 16'hFFEA);
    tick(1);
    b.irqIn = '0;
    check("edge_pend", 32'(b.pending), 32'h20);
    tick(1);
    wait_req("edge5");
    ack();
    check("edge_ack_pend", 32'(b.pending), 32'h0);
    check("edge_ack_isr", 32'(b.inService), 32'h20);
    b.irqIn = 8'h20;
    tick(1);
    b.irqIn = '0;
    check("edge_rearm_pend", 32'(b.pending), 32'h20);
    tick(2);
    check("edge_in_service_hold", 32'(b.intReq), 32'h0);
    push_exp(1'b0, 16'hFFEA);
    done();
    wait_req("edge5_again");
    ack();
    done();
    check("edge_done", 32'(b.inService), 32'h0);
    cfg(CFG_MASK, 8'h00);
    b.irqIn = 8'h20;
    tick(1);
    b.irqIn = '0;
    check("clr_setup", 32'(b.pending), 32'h20);
    cfg(CFG_CLR, 8'h20);
    check("clr_write", 32'(b.pending), 32'h0);
    b.cfgWrite = 1'b1;
    b.cfgSel   = CFG_CLR;
    b.cfgData  = 8'h20;
    b.irqIn    = 8'h20;
    tick(1);
    b.cfgWrite = 1'b0;
    b.irqIn    = '0;
    check("clr_vs_edge", 32'(b.pending), 32'h20);
    cfg(CFG_CLR, 8'h20);
    cfg(CFG_SET, 8'h28);
    check("set_edge_only", 32'(b.pending), 32'h20);
    cfg(CFG_CLR, 8'h20);

    // Nesting under IRQ 4.
    cfg(CFG_MODE, 8'h00);
    cfg(CFG_MASK, 8'h54);
    b.irqIn = 8'h10;
    push_exp(1'b0, 16'hFFE8);
    wait_req("nest4");
    ack();
    check("nest4_isr", 32'(b.inService), 32'h10);
    b.irqIn = 8'h54;
    push_exp(1'b0, 16'hFFE4);
    wait_req("nest2");
    ack();
    check("nest2_isr", 32'(b.inService), 32'h14);
    tick(2);
    check("nest6_blocked", 32'(b.intReq), 32'h0);
    b.irqIn = 8'h50;
    done();
    check("nest_done2", 32'(b.inService), 32'h10);
    tick(2);
    check("nest6_still_blocked", 32'(b.intReq), 32'h0);
    b.irqIn = 8'h40;
    push_exp(1'b0, 16'hFFEC);
    done();
    check("nest_done4", 32'(b.inService), 32'h0);
    wait_req("nest6");
    ack();
    b.irqIn = '0;
    done();
    check("nest_clear", 32'(b.inService), 32'h0);

    // NMI preempts a presented IRQ, merges repeat edges, ignores irqEn.
    cfg(CFG_MASK, 8'h02);
    b.irqIn = 8'h02;
    push_exp(1'b0, 16'hFFE2);
    wait_req("nmi_irq1");
    b.nmiReq = 1'b1;
    push_exp(1'b1, 16'hFFFA);
    tick(2);
    check("nmi_abandon", 32'(b.intReq), 32'h0);
    check("nmi_abandon_isr", 32'(b.inService), 32'h0);
    wait_req("nmi1");
    b.irqEn = 1'b0;
    ack();
    check("nmi_ack_drop", 32'(b.intReq), 32'h0);
    b.nmiReq = 1'b0;
    tick(1);
    b.nmiReq = 1'b1;
    tick(1);
    b.nmiReq = 1'b0;
    tick(1);
    b.nmiReq = 1'b1;
    tick(1);
    check("nmi_in_service_hold", 32'(b.intReq), 32'h0);
    push_exp(1'b1, 16'hFFFA);
    done();
    wait_req("nmi_merged");
    ack();
    tick(3);
    check("nmi_merged_once", 32'(b.intReq), 32'h0);
    done();
    tick(2);
    check("irq_en_blocks", 32'(b.intReq), 32'h0);
    b.irqEn = 1'b1;
    push_exp(1'b0, 16'hFFE2);
    wait_req("irq1_after_nmi");
    ack();
    b.irqIn  = '0;
    b.nmiReq = 1'b0;
    done();
    check("nmi_seq_isr", 32'(b.inService), 32'h0);

    // Withdrawal, ignored ack/done, reset mid-request.
    cfg(CFG_MASK, 8'h08);
    b.irqIn = 8'h08;
    push_exp(1'b0, 16'hFFE6);
    wait_req("wd");
    b.irqIn = '0;
    tick(2);
    check("wd_drop", 32'(b.intReq), 32'h0);
    check("wd_isr", 32'(b.inService), 32'h0);
    ack();
    check("idle_ack_ignored", 32'(b.inService), 32'h0);
    done();
    check("idle_done_ignored", 32'(b.inService), 32'h0);
    b.irqIn = 8'h08;
    push_exp(1'b0, 16'hFFE6);
    wait_req("rst_mid");
    resetReq = 1'b1;
    tick(1);
    check("rst_mid_req", 32'(b.intReq), 32'h0);
    check("rst_mid_nmi", 32'(b.intNmi), 32'h0);
    check("rst_mid_vec", 32'(b.intVector), 32'h0);
    check("rst_mid_pend", 32'(b.pending), 32'h0);
    check("rst_mid_isr", 32'(b.inService), 32'h0);
    resetReq = 1'b0;
    b.irqIn  = '0;
    tick(3);
    check("rst_mid_quiet", 32'(b.intReq), 32'h0);

    // 16 sources with a base near the top of the address space.
    b16.irqEn    = 1'b1;
    b16.cfgWrite = 1'b1;
    b16.cfgSel   = CFG_MASK;
    b16.cfgData  = 16'h8000;
    tick(1);
    b16.cfgWrite = 1'b0;
    b16.irqIn    = 16'h8000;
    n = 0;
    while (b16.intReq !== 1'b1 && n < 8) begin
      tick(1);
      n++;
    end
    check("w16_req", 32'(b16.intReq), 32'h1);
    check("w16_nmi", 32'(b16.intNmi), 32'h0);
    check("w16_vec", 32'(b16.intVector), 32'h000E);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
